// File: rtl/clock_gate_ctrl_if.sv
// Sleep/idle handshake and clock-gate status between the core, the gate sequencer and the BUFGCE.
interface clock_gate_ctrl_if;
  logic idle_i;
  logic wake_i;
  logic force_on_i;
  logic sleep_ack_i;
  logic sleep_req_o;
  logic en_o;
  logic gated_o;
  logic clk_ready_o;

  modport master (
    input  idle_i, wake_i, force_on_i, sleep_ack_i,
    output sleep_req_o, en_o, gated_o, clk_ready_o
  );

  modport slave (
    output idle_i, wake_i, force_on_i, sleep_ack_i,
    input  sleep_req_o, en_o, gated_o, clk_ready_o
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Core clock-gate sequencer: idle qualification, sleep handshake, settle before gating, timed wake.
// state     | meaning
// RUN       | clock running, counting qualifying idle cycles
// DRAIN     | sleep requested, waiting for core ack or abort
// GATE_WAIT | en dropped, waiting for BUFGCE to stop the clock
// GATED     | clock stopped, waiting for wake/force
// WAKE_WAIT | en raised, waiting for clock to become stable
module clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  clock_gate_ctrl_if.master   pm_if
);

  localparam int unsigned MAX_A   = (IDLE_CYCLES > SETTLE_CYCLES) ? IDLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > WAKE_CYCLES) ? MAX_A : WAKE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] IDLE_TC   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_TC   = CNT_W'(WAKE_CYCLES - 1);

  localparam logic [2:0] ST_RUN       = 3'd0;
  localparam logic [2:0] ST_DRAIN     = 3'd1;
  localparam logic [2:0] ST_GATE_WAIT = 3'd2;
  localparam logic [2:0] ST_GATED     = 3'd3;
  localparam logic [2:0] ST_WAKE_WAIT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qidle;
  logic             wake_any;

  assign qidle    = pm_if.idle_i & ~pm_if.wake_i & ~pm_if.force_on_i;
  assign wake_any = pm_if.wake_i | pm_if.force_on_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!qidle) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_TC) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        // abort wins over a simultaneous ack
        if (wake_any || !pm_if.idle_i) begin
          state_d = ST_RUN;
        end else if (pm_if.sleep_ack_i) begin
          state_d = ST_GATE_WAIT;
        end
      end
      ST_GATE_WAIT: begin
        if (wake_any) begin
          state_d = ST_WAKE_WAIT;
        end else if (cnt_q == SETTLE_TC) begin
          state_d = ST_GATED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GATED: begin
        if (wake_any) begin
          state_d = ST_WAKE_WAIT;
        end
      end
      ST_WAKE_WAIT: begin
        if (cnt_q == WAKE_TC) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pm_if.en_o        = 1'b1;
    pm_if.sleep_req_o = 1'b0;
    pm_if.gated_o     = 1'b0;
    pm_if.clk_ready_o = 1'b1;
    case (state_q)
      ST_DRAIN: begin
        pm_if.sleep_req_o = 1'b1;
      end
      ST_GATE_WAIT: begin
        pm_if.en_o        = 1'b0;
        pm_if.sleep_req_o = 1'b1;
        pm_if.clk_ready_o = 1'b0;
      end
      ST_GATED: begin
        pm_if.en_o        = 1'b0;
        pm_if.sleep_req_o = 1'b1;
        pm_if.gated_o     = 1'b1;
        pm_if.clk_ready_o = 1'b0;
      end
      ST_WAKE_WAIT: begin
        pm_if.sleep_req_o = 1'b1;
        pm_if.clk_ready_o = 1'b0;
      end
      default: begin
        pm_if.en_o = 1'b1;
      end
    endcase
  end

endmodule
